// File: rtl/stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : stream_pkg                                                     |
// | Purpose : Shared types and helpers for the pixel-stream to SDRAM         |
// |           framebuffer writer (FIFO entry layout, writer FSM states,      |
// |           pixel address computation).                                    |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package stream_pkg;

  localparam int C_DATA_W = 32;

  // One buffered stream word plus the start-of-frame marker derived from
  // the stream address (adr == 0 marks pixel 0 of a frame).
  typedef struct packed {
    logic                sof;
    logic [C_DATA_W-1:0] data;
  } fifo_entry_t;

  localparam int C_ENTRY_W = $bits(fifo_entry_t);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

  // Byte address of a pixel; 32-bit arithmetic wraps modulo 2^32.
  function automatic logic [31:0] pix_adr(input logic [31:0] base,
                                          input logic [31:0] idx);
    return base + (idx << 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wshb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface: wshb_if                                                       |
// | Purpose  : Classic Wishbone bus bundle with 32-bit byte address.         |
// |            master : drives cyc/stb/we/adr/dat_ms/sel/cti/bte            |
// |            slave  : drives ack/err/rty/dat_sm                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface wshb_if #(
  parameter int DATA_BYTES = 4
) ();

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [DATA_BYTES-1:0]   sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output dat_sm, ack, err, rty
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : sync_fifo                                                      |
// | Purpose : Single-clock show-ahead FIFO, power-of-two depth.              |
// | Ports   : sys_clk, sys_rst (async, active-high)                          |
// |           push/din   - write when not full (ignored when full)           |
// |           pop/dout   - dout always shows the head; pop when not empty    |
// |           full/empty - occupancy flags                                   |
// |           level      - registered occupancy after the current edge       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_level == C_FULL);
  assign empty     = (r_level == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign dout      = r_mem[r_rd_ptr];
  assign level     = r_level;

  // Storage carries no reset: contents are meaningless once the pointers
  // and level are cleared.
  always_ff @(posedge sys_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_to_sdram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : stream_to_sdram                                                |
// | Purpose : Wishbone responder for the pixel stream. Accepted words are    |
// |           buffered and re-issued as classic single Wishbone writes into  |
// |           the SDRAM framebuffer, one pixel per 32-bit word.              |
// | Ports   : sys_clk    - system clock                                      |
// |           sys_rst    - asynchronous, active-high reset                   |
// |           wshb_ifs   - stream responder (writes pushed, reads -> err)    |
// |           wshb_ifm   - SDRAM write initiator                             |
// |           frame_done - one-cycle pulse after last pixel of a frame acked |
// |           fifo_level - registered FIFO occupancy                         |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module stream_to_sdram
  import stream_pkg::*;
#(
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h0
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  wshb_if.slave                         wshb_ifs,
  wshb_if.master                        wshb_ifm,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                NPIX       = HDISP * VDISP;
  localparam int                IDX_W      = $clog2(NPIX);
  localparam logic [IDX_W-1:0]  C_LAST_IDX = IDX_W'(NPIX - 1);

  // ---------------------------------------------------------------------
  // Stream responder
  // ---------------------------------------------------------------------
  logic        r_ack;
  logic        r_err;
  logic        w_wr_req;
  logic        w_rd_req;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  fifo_entry_t w_din;
  fifo_entry_t w_head;

  // The !ack / !err terms stop a held request from being serviced twice,
  // which yields the registered-ack rate of one response every two cycles.
  assign w_wr_req = wshb_ifs.cyc & wshb_ifs.stb & wshb_ifs.we & ~r_ack;
  assign w_rd_req = wshb_ifs.cyc & wshb_ifs.stb & ~wshb_ifs.we & ~r_err;
  assign w_push   = w_wr_req & ~w_full;

  assign w_din.sof  = (wshb_ifs.adr == 32'h0);
  assign w_din.data = wshb_ifs.dat_ms;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_push;
      r_err <= w_rd_req;
    end
  end

  assign wshb_ifs.ack    = r_ack;
  assign wshb_ifs.err    = r_err;
  assign wshb_ifs.rty    = 1'b0;
  assign wshb_ifs.dat_sm = '0;

  sync_fifo #(
    .WIDTH (C_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_din),
    .dout    (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  // ---------------------------------------------------------------------
  // SDRAM writer
  // ---------------------------------------------------------------------
  wr_state_t        r_state;
  wr_state_t        w_state_nxt;
  logic             r_cyc,  w_cyc_nxt;
  logic             r_stb,  w_stb_nxt;
  logic             r_we,   w_we_nxt;
  logic [31:0]      r_adr,  w_adr_nxt;
  logic [31:0]      r_dat,  w_dat_nxt;
  logic [3:0]       r_sel,  w_sel_nxt;
  logic [2:0]       r_cti,  w_cti_nxt;
  logic [1:0]       r_bte,  w_bte_nxt;
  logic [IDX_W-1:0] r_cur_idx, w_cur_idx_nxt;
  logic [IDX_W-1:0] r_pix_idx, w_pix_idx_nxt;
  logic             r_frame_done, w_frame_done_nxt;
  logic [IDX_W-1:0] w_idx_sel;

  // A start-of-frame word resynchronises the pixel counter to 0.
  assign w_idx_sel = w_head.sof ? '0 : r_pix_idx;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cyc_nxt        = r_cyc;
    w_stb_nxt        = r_stb;
    w_we_nxt         = r_we;
    w_adr_nxt        = r_adr;
    w_dat_nxt        = r_dat;
    w_sel_nxt        = r_sel;
    w_cti_nxt        = r_cti;
    w_bte_nxt        = r_bte;
    w_cur_idx_nxt    = r_cur_idx;
    w_pix_idx_nxt    = r_pix_idx;
    w_frame_done_nxt = 1'b0;
    w_pop            = 1'b0;
    case (r_state)
      IDLE: begin
        // The head stays in the FIFO until acknowledged, so a retried
        // word is simply reloaded from here with the same address.
        if (!w_empty) begin
          w_cyc_nxt     = 1'b1;
          w_stb_nxt     = 1'b1;
          w_we_nxt      = 1'b1;
          w_adr_nxt     = pix_adr(BASE_ADR, 32'(w_idx_sel));
          w_dat_nxt     = w_head.data;
          w_sel_nxt     = 4'hF;
          w_cti_nxt     = 3'b000;
          w_bte_nxt     = 2'b00;
          w_cur_idx_nxt = w_idx_sel;
          w_state_nxt   = WRITE;
        end
      end
      WRITE: begin
        if (wshb_ifm.ack || wshb_ifm.err) begin
          // An errored word is discarded but still consumes its pixel slot.
          w_pop            = 1'b1;
          w_pix_idx_nxt    = (r_cur_idx == C_LAST_IDX) ? '0 : r_cur_idx + 1'b1;
          w_frame_done_nxt = (r_cur_idx == C_LAST_IDX);
          w_cyc_nxt        = 1'b0;
          w_stb_nxt        = 1'b0;
          w_state_nxt      = IDLE;
        end else if (wshb_ifm.rty) begin
          w_cyc_nxt   = 1'b0;
          w_stb_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cyc        <= 1'b0;
      r_stb        <= 1'b0;
      r_we         <= 1'b0;
      r_adr        <= '0;
      r_dat        <= '0;
      r_sel        <= '0;
      r_cti        <= '0;
      r_bte        <= '0;
      r_cur_idx    <= '0;
      r_pix_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cyc        <= w_cyc_nxt;
      r_stb        <= w_stb_nxt;
      r_we         <= w_we_nxt;
      r_adr        <= w_adr_nxt;
      r_dat        <= w_dat_nxt;
      r_sel        <= w_sel_nxt;
      r_cti        <= w_cti_nxt;
      r_bte        <= w_bte_nxt;
      r_cur_idx    <= w_cur_idx_nxt;
      r_pix_idx    <= w_pix_idx_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign wshb_ifm.cyc    = r_cyc;
  assign wshb_ifm.stb    = r_stb;
  assign wshb_ifm.we     = r_we;
  assign wshb_ifm.adr    = r_adr;
  assign wshb_ifm.dat_ms = r_dat;
  assign wshb_ifm.sel    = r_sel;
  assign wshb_ifm.cti    = r_cti;
  assign wshb_ifm.bte    = r_bte;
  assign frame_done      = r_frame_done;

  // Bus fields this block has no use for: stream byte lanes and burst
  // hints (every word is stored whole) and SDRAM read data.
  logic w_unused_ok;
  assign w_unused_ok = ^{wshb_ifs.sel, wshb_ifs.cti, wshb_ifs.bte, wshb_ifm.dat_sm};

endmodule
`default_nettype wire
